// File: rtl/uart_string_transmitter_pkg.sv
// uart_string_transmitter_pkg: shared constants, message ROM and FSM state types
// Contents: MSG_LEN, DATA_BITS, MSG byte array, ctrl_state_t, tx_state_t
package uart_string_transmitter_pkg;

    localparam int MSG_LEN   = 12;
    localparam int DATA_BITS = 8;

    // "hello spence", index 0 is sent first
    localparam logic [7:0] MSG [MSG_LEN] = '{
        8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
        8'h73, 8'h70, 8'h65, 8'h6E, 8'h63, 8'h65
    };

    typedef enum logic [1:0] {
        C_IDLE,
        C_LOAD,
        C_WAIT_DONE,
        C_NEXT
    } ctrl_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_WAIT_RX,
        T_START,
        T_DATA,
        T_STOP,
        T_DONE
    } tx_state_t;

endpackage

// File: rtl/uart_string_transmitter_transmit_fsm.sv
// transmit_fsm: 8N1 frame generator with baud counter and receiver flow control
// Ports: i_clk, i_rst (async high), i_tx_en (latch i_byte, start frame),
//        i_byte, i_receiver_done (frame may start), o_tx_done (1-cycle pulse),
//        o_uart (registered serial line, idle high)
module transmit_fsm
    import uart_string_transmitter_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_en,
    input  logic [7:0] i_byte,
    input  logic       i_receiver_done,
    output logic       o_tx_done,
    output logic       o_uart
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t            r_state, w_next;
    logic [BW-1:0]        r_baud;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_bit;
    logic                 r_uart;
    logic                 w_tick;
    logic                 w_uart;

    assign w_tick    = r_baud == BW'(CLKS_PER_BIT - 1);
    assign o_tx_done = r_state == T_DONE;
    assign o_uart    = r_uart;

    always_comb begin
        w_next = r_state;
        case (r_state)
            T_IDLE:    if (i_tx_en) w_next = T_WAIT_RX;
            T_WAIT_RX: if (i_receiver_done) w_next = T_START;
            T_START:   if (w_tick) w_next = T_DATA;
            T_DATA:    if (w_tick && r_bit == 3'(DATA_BITS - 1)) w_next = T_STOP;
            T_STOP:    if (w_tick) w_next = T_DONE;
            T_DONE:    w_next = T_IDLE;
            default:   w_next = T_IDLE;
        endcase
        // Output is computed from the next state so the line register flips on
        // the same edge as the state register; on a data tick the shifter has
        // not moved yet, so the upcoming bit is r_shift[1]
        w_uart = (w_next == T_START) ? 1'b0 :
                 (w_next != T_DATA)  ? 1'b1 :
                 (r_state == T_DATA && w_tick) ? r_shift[1] : r_shift[0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= T_IDLE;
            r_baud  <= '0;
            r_shift <= '0;
            r_bit   <= '0;
            r_uart  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_uart  <= w_uart;
            r_baud  <= (r_state inside {T_START, T_DATA, T_STOP} && !w_tick) ? r_baud + 1'b1 : '0;
            r_bit   <= (r_state == T_DATA) ? r_bit + 3'(w_tick) : '0;
            if (r_state == T_IDLE && i_tx_en)
                r_shift <= i_byte;
            else if (r_state == T_DATA && w_tick)
                r_shift <= r_shift >> 1;
        end
    end

endmodule

// File: rtl/uart_string_transmitter.sv
// uart_string_transmitter: sends "hello spence" over UART on each button press
// Ports: CLOCK_50 (clock), reset (async high), button_ (active-low press),
//        receiver_done (1 = next frame may start), uart_out (8N1 line, idle high)
module uart_string_transmitter
    import uart_string_transmitter_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic button_,
    input  logic receiver_done,
    output logic uart_out
);

    logic [1:0]  r_sync;
    logic        r_prev;
    ctrl_state_t r_state, w_next;
    logic [3:0]  r_idx;
    logic        w_press;
    logic        w_last;
    logic        w_tx_en;
    logic        w_tx_done;
    logic [7:0]  w_byte;

    // Falling edge of the synchronized button; r_prev holds the previous r_sync[1]
    assign w_press = r_prev & ~r_sync[1];
    assign w_last  = r_idx == 4'(MSG_LEN - 1);
    assign w_byte  = MSG[r_idx];

    always_comb begin
        w_next  = r_state;
        w_tx_en = 1'b0;
        case (r_state)
            C_IDLE:      if (w_press) w_next = C_LOAD;
            C_LOAD: begin
                w_tx_en = 1'b1;
                w_next  = C_WAIT_DONE;
            end
            C_WAIT_DONE: if (w_tx_done) w_next = C_NEXT;
            C_NEXT:      w_next = w_last ? C_IDLE : C_LOAD;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_prev  <= 1'b1;
            r_state <= C_IDLE;
            r_idx   <= '0;
        end else begin
            r_sync  <= {r_sync[0], button_};
            r_prev  <= r_sync[1];
            r_state <= w_next;
            if (r_state == C_NEXT)
                r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
    end

    transmit_fsm #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .i_clk          (CLOCK_50),
        .i_rst          (reset),
        .i_tx_en        (w_tx_en),
        .i_byte         (w_byte),
        .i_receiver_done(receiver_done),
        .o_tx_done      (w_tx_done),
        .o_uart         (uart_out)
    );

endmodule

// File: tb/tb_uart_string_transmitter.sv
// tb_uart_string_transmitter: directed bench decoding the serial line of two DUTs (1 and 4 clocks per bit)
module tb_uart_string_transmitter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn1 = 1'b1;
    logic btn4 = 1'b1;
    logic rd = 1'b1;
    logic sel4 = 1'b0;
    logic uo1, uo4, w_line;
    int   checks = 0;
    int   errors = 0;
    int   starts = 0;
    time  last_start = 0;
    time  t_rd = 0;
    time  fst [12];
    logic [7:0] exp_msg [12] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                                 8'h73, 8'h70, 8'h65, 8'h6E, 8'h63, 8'h65};

    always #5 clk = ~clk;

    assign w_line = sel4 ? uo4 : uo1;

    uart_string_transmitter #(.CLKS_PER_BIT(1)) u_dut1 (
        .CLOCK_50(clk), .reset(rst), .button_(btn1), .receiver_done(rd), .uart_out(uo1)
    );

    uart_string_transmitter #(.CLKS_PER_BIT(4)) u_dut4 (
        .CLOCK_50(clk), .reset(rst), .button_(btn4), .receiver_done(rd), .uart_out(uo4)
    );

    task automatic quiet(input int n, input string name);
        int lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (w_line !== 1'b1) lows++;
        end
        checks++;
        if (lows !== 0) begin
            errors++;
            $display("FAIL %s low_samples=%0d required=0", name, lows);
        end
    endtask

    task automatic press(input bit four);
        @(negedge clk);
        if (four) btn4 = 1'b0; else btn1 = 1'b0;
        repeat (2) @(negedge clk);
        btn1 = 1'b1;
        btn4 = 1'b1;
    endtask

    task automatic recv_frame(input int cpb, input int limit, output logic [7:0] data, output int waited);
        logic [9:0] bits;
        logic       bad;
        data   = '0;
        waited = 0;
        bad    = 1'b0;
        bits   = '0;
        do begin
            @(negedge clk);
            waited++;
        end while (w_line !== 1'b0 && waited < limit);
        checks++;
        if (w_line !== 1'b0) begin
            errors++;
            $display("FAIL start_timeout waited=%0d limit=%0d", waited, limit);
            return;
        end
        starts++;
        last_start = $time;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < cpb; k++) begin
                if (b != 0 || k != 0) @(negedge clk);
                if (k == 0) bits[b] = w_line;
                else if (w_line !== bits[b]) bad = 1'b1;
            end
        end
        data = bits[8:1];
        checks++;
        if (bad || bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
            errors++;
            $display("FAIL framing bits=%b width_glitch=%0d required start=0 stop=1 uniform", bits, bad);
        end
    endtask

    task automatic recv_msg(input int cpb, input bit chk_gap, output int first_wait);
        logic [7:0] d;
        int         w;
        first_wait = 0;
        for (int i = 0; i < 12; i++) begin
            recv_frame(cpb, (i == 0) ? 10 : 200, d, w);
            fst[i] = last_start;
            if (i == 0) first_wait = w;
            checks++;
            if (d !== exp_msg[i]) begin
                errors++;
                $display("FAIL char%0d got=%h required=%h", i, d, exp_msg[i]);
            end
            if (chk_gap && i > 0) begin
                checks++;
                if (w - 1 > 3 + cpb) begin
                    errors++;
                    $display("FAIL gap%0d idle=%0d max=%0d", i, w - 1, 3 + cpb);
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (uo1 !== 1'b1 || uo4 !== 1'b1) begin
                errors++;
                $display("FAIL reset_line got=%b%b required=11", uo1, uo4);
            end
        end
        rst = 1'b0;
        quiet(30, "reset_idle1");
        sel4 = 1'b1;
        quiet(10, "reset_idle4");
        sel4 = 1'b0;
    endtask

    task automatic test_message;
        int fw;
        sel4 = 1'b0;
        press(1'b0);
        recv_msg(1, 1'b1, fw);
        checks++;
        if (2 + fw - 1 > 6) begin
            errors++;
            $display("FAIL latency got=%0d max=6", 2 + fw - 1);
        end
        quiet(40, "after_msg");
    endtask

    task automatic test_flow;
        int fw;
        int base;
        base = starts;
        press(1'b0);
        fork
            recv_msg(1, 1'b0, fw);
            begin
                int k = 0;
                while (starts < base + 2 && k < 300) begin
                    @(negedge clk);
                    k++;
                end
                repeat (3) @(negedge clk);
                rd = 1'b0;
                repeat (20) @(negedge clk);
                rd = 1'b1;
                t_rd = $time;
            end
        join
        checks++;
        if (fst[2] <= t_rd) begin
            errors++;
            $display("FAIL flow_hold frame2_start=%0t required_after=%0t", fst[2], t_rd);
        end
        quiet(20, "after_flow");
    endtask

    task automatic test_ignore;
        int fw;
        int base;
        base = starts;
        press(1'b0);
        fork
            recv_msg(1, 1'b1, fw);
            begin
                int k = 0;
                while (starts < base + 3 && k < 300) begin
                    @(negedge clk);
                    k++;
                end
                repeat (4) @(negedge clk);
                press(1'b0);
            end
        join
        quiet(60, "no_requeue");
        checks++;
        if (starts - base !== 12) begin
            errors++;
            $display("FAIL frame_count got=%0d required=12", starts - base);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        int         w;
        int         k;
        int         fw;
        press(1'b0);
        recv_frame(1, 10, d, w);
        recv_frame(1, 200, d, w);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (uo1 !== 1'b0 && k < 50);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (uo1 !== 1'b1) begin
            errors++;
            $display("FAIL async_reset line=%b required=1", uo1);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        quiet(40, "post_reset");
        press(1'b0);
        recv_msg(1, 1'b1, fw);
        quiet(20, "after_restart");
    endtask

    task automatic test_cpb4;
        int fw;
        sel4 = 1'b1;
        press(1'b1);
        recv_msg(4, 1'b1, fw);
        quiet(40, "after_msg4");
        sel4 = 1'b0;
    endtask

    initial begin
        test_reset;
        test_message;
        test_flow;
        test_ignore;
        test_reset_mid;
        test_cpb4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
